hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/aurora_hdu_pkg.sv | 21 ++
 rtl/hdu_sb_entry.sv | 26 ++
 rtl/hazard_scoreboard.sv | 70 +++++++
 3 files changed

// File: rtl/aurora_hdu_pkg.sv
// Shared defaults and elaboration helpers for the hazard-detection scoreboard.
package aurora_hdu_pkg;

    localparam int REG_AW_D   = 3;
    localparam int LAT_ALU_D  = 2;
    localparam int LAT_LOAD_D = 3;
    localparam int FWD_DIST_D = 0;
    localparam int STALL_CW_D = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hdu_sb_entry.sv
// One register's pending-write down-counter; a set loads the larger of the
// decremented count and the new latency so a WAW never shortens the wait.
module hdu_sb_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set,
    input  logic [CNT_W-1:0] lat,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] dec;

    assign dec = (cnt != '0) ? cnt - CNT_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (set)
            cnt <= (dec > lat) ? dec : lat;
        else
            cnt <= dec;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: stalls ID while a source register still has a write in
// flight beyond the forwarding window, and tracks the stall-cycle count.
module hazard_scoreboard
    import aurora_hdu_pkg::*;
#(
    parameter int REG_AW   = REG_AW_D,
    parameter int LAT_ALU  = LAT_ALU_D,
    parameter int LAT_LOAD = LAT_LOAD_D,
    parameter int FWD_DIST = FWD_DIST_D,
    parameter int STALL_CW = STALL_CW_D
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                id_valid_i,
    input  logic [REG_AW-1:0]   id_rs1_i,
    input  logic [REG_AW-1:0]   id_rs2_i,
    input  logic                id_rs1_used_i,
    input  logic                id_rs2_used_i,
    input  logic [REG_AW-1:0]   id_rd_i,
    input  logic                id_reg_write_i,
    input  logic                id_load_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                issue_o,
    output logic                busy_o,
    output logic [STALL_CW-1:0] stall_cnt_o
);

    localparam int NREGS = 2 ** REG_AW;
    localparam int CNT_W = clog2(max2(LAT_ALU, LAT_LOAD) + 1);

    logic [NREGS-1:0][CNT_W-1:0] pend;
    logic [NREGS-1:0]            set_vec;
    logic [CNT_W-1:0]            lat_sel;
    logic                        rs1_haz, rs2_haz;

    // Hazard check reads the registered counters, so an instruction whose rd
    // equals its own rs never sees its own set.
    assign rs1_haz = id_rs1_used_i && (id_rs1_i != '0) && (int'(pend[id_rs1_i]) > FWD_DIST);
    assign rs2_haz = id_rs2_used_i && (id_rs2_i != '0) && (int'(pend[id_rs2_i]) > FWD_DIST);

    assign stall_o = id_valid_i && !flush_i && (rs1_haz || rs2_haz);
    assign issue_o = id_valid_i && !flush_i && !stall_o;
    assign busy_o  = |pend;
    assign lat_sel = id_load_i ? CNT_W'(LAT_LOAD) : CNT_W'(LAT_ALU);

    always_comb begin
        set_vec = '0;
        if (issue_o && id_reg_write_i && (id_rd_i != '0))
            set_vec[id_rd_i] = 1'b1;
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_ent
        hdu_sb_entry #(.CNT_W(CNT_W)) u_ent (
            .clk   (clk_i),
            .rst_n (rst_n_i),
            .set   (set_vec[g]),
            .lat   (lat_sel),
            .cnt   (pend[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            stall_cnt_o <= '0;
        else if (stall_o && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + STALL_CW'(1);
    end

endmodule
